// File: rtl/cdb_arbiter_pkg.sv
// cpu_params: shared CPU parameters and the common-data-bus payload types.
//   CDB_WIDTH  - number of CDB lanes / PRF write ports
//   PRF_IDX_W  - physical register index width
//   ROB_IDX_W  - ROB index width
//   DATA_W     - result data width
//   CNT_W      - width of the optional saturating performance counters
// cdb_req_t is the writeback payload; cdb_lane_t is the same layout used for
// a broadcast lane. sat_inc is the saturating increment for the counters.
package cpu_params;

   localparam int CDB_WIDTH = 2;
   localparam int PRF_IDX_W = 6;
   localparam int ROB_IDX_W = 5;
   localparam int DATA_W    = 32;
   localparam int CNT_W     = 32;

   typedef struct packed {
      logic [PRF_IDX_W-1:0] rd_phy;
      logic [DATA_W-1:0]    rd_value;
      logic [ROB_IDX_W-1:0] rob_id;
   } cdb_req_t;

   typedef cdb_req_t cdb_lane_t;

   // Increment that sticks at all-ones instead of wrapping to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      logic [CNT_W-1:0] result;
      if (value == {CNT_W{1'b1}}) begin
         result = value;
      end else begin
         result = value + 32'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/cdb_arbiter_picker.sv
// rr_multi_picker: purely combinational multi-grant round-robin picker.
// Scans requesters starting at rr_ptr (wrapping) and hands the first valid
// one to lane 0, the next to lane 1, and so on, up to N_LANE grants.
// Ports:
//   req_valid [N_REQ]          requester holds a result
//   rr_ptr    [PTR_W]          requester with highest priority this cycle
//   grant     [N_LANE][N_REQ]  one-hot requester select per lane (0 if idle)
//   any_grant                  at least one lane granted
//   next_ptr  [PTR_W]          (last granted index + 1) mod N_REQ, else rr_ptr
module rr_multi_picker
   import cpu_params::*;
#(
   parameter int N_REQ  = 4,
   parameter int N_LANE = CDB_WIDTH,
   parameter int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [PTR_W-1:0]              rr_ptr,
   output logic [N_LANE-1:0][N_REQ-1:0]  grant,
   output logic                          any_grant,
   output logic [PTR_W-1:0]              next_ptr
);

   // Rank each valid requester by its distance from rr_ptr; rank k wins lane k.
   always_comb begin
      int off_s [N_REQ];
      int rank_s;
      int last_off_s;
      int last_idx_s;
      grant      = '0;
      any_grant  = 1'b0;
      next_ptr   = rr_ptr;
      rank_s     = 0;
      last_off_s = -1;
      last_idx_s = 0;
      for (int i = 0; i < N_REQ; i++) begin
         off_s[i] = i - int'(rr_ptr);
         if (off_s[i] < 0) begin
            off_s[i] = off_s[i] + N_REQ;
         end else begin
            off_s[i] = off_s[i];
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         // rank = number of valid requesters scanned before this one
         rank_s = 0;
         for (int j = 0; j < N_REQ; j++) begin
            if (req_valid[j] && (off_s[j] < off_s[i])) begin
               rank_s = rank_s + 1;
            end else begin
               rank_s = rank_s;
            end
         end
         for (int k = 0; k < N_LANE; k++) begin
            if (req_valid[i] && (rank_s == k)) begin
               grant[k][i] = 1'b1;
               any_grant   = 1'b1;
               if (off_s[i] > last_off_s) begin
                  last_off_s = off_s[i];
                  last_idx_s = i;
               end else begin
                  last_off_s = last_off_s;
               end
            end else begin
               grant[k][i] = grant[k][i];
            end
         end
      end
      if (!any_grant) begin
         next_ptr = rr_ptr;
      end else if (last_idx_s == N_REQ - 1) begin
         next_ptr = '0;
      end else begin
         next_ptr = PTR_W'(last_idx_s + 1);
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin writeback arbiter from N_REQ functional units onto
// CDB_WIDTH common-data-bus lanes. Grants are combinational (req_ready); the
// lane broadcast is registered and appears exactly one cycle after its grant.
// Optional build macro CDB_ARB_PERF_EN adds saturating stall/full counters.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    suppresses all grants this cycle; rr_ptr held
//   req_valid/req_ready      per-requester handshake (ready depends on valid)
//   req_rd_phy/value/rob_id  flattened per-requester payload
//   cdb_valid                per-lane broadcast valid (lanes fill from 0)
//   cdb_rd_phy/value/rob_id  flattened per-lane payload (held when invalid)
//   stall_cnt, full_cycles   perf counters (CDB_ARB_PERF_EN only)
module cdb_arbiter
   import cpu_params::*;
#(
   parameter int N_REQ = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic [N_REQ-1:0]               req_valid,
   output logic [N_REQ-1:0]               req_ready,
   input  logic [N_REQ*PRF_IDX_W-1:0]     req_rd_phy,
   input  logic [N_REQ*DATA_W-1:0]        req_rd_value,
   input  logic [N_REQ*ROB_IDX_W-1:0]     req_rob_id,
   output logic [CDB_WIDTH-1:0]           cdb_valid,
   output logic [CDB_WIDTH*PRF_IDX_W-1:0] cdb_rd_phy,
   output logic [CDB_WIDTH*DATA_W-1:0]    cdb_rd_value,
   output logic [CDB_WIDTH*ROB_IDX_W-1:0] cdb_rob_id
`ifdef CDB_ARB_PERF_EN
   ,
   output logic [N_REQ*CNT_W-1:0]         stall_cnt,
   output logic [CNT_W-1:0]               full_cycles
`endif
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PTR_W-1:0]                    rr_ptr_r;
   logic [CDB_WIDTH-1:0][N_REQ-1:0]     grant_s;
   logic                                any_grant_s;
   logic [PTR_W-1:0]                    next_ptr_s;
   logic [CDB_WIDTH-1:0]                lane_hit_s;
   cdb_lane_t [CDB_WIDTH-1:0]           lane_sel_s;
   cdb_lane_t [CDB_WIDTH-1:0]           lane_r;
   logic [CDB_WIDTH-1:0]                cdb_valid_r;

   rr_multi_picker #(
      .N_REQ  (N_REQ),
      .N_LANE (CDB_WIDTH),
      .PTR_W  (PTR_W)
   ) u_picker (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_r),
      .grant     (grant_s),
      .any_grant (any_grant_s),
      .next_ptr  (next_ptr_s)
   );

   // Flush gating of grants and one-hot payload selection per lane.
   always_comb begin
      req_ready  = '0;
      lane_hit_s = '0;
      lane_sel_s = '0;
      for (int k = 0; k < CDB_WIDTH; k++) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (grant_s[k][i]) begin
               lane_sel_s[k].rd_phy   = req_rd_phy[i*PRF_IDX_W +: PRF_IDX_W];
               lane_sel_s[k].rd_value = req_rd_value[i*DATA_W +: DATA_W];
               lane_sel_s[k].rob_id   = req_rob_id[i*ROB_IDX_W +: ROB_IDX_W];
            end else begin
               lane_sel_s[k] = lane_sel_s[k];
            end
         end
      end
      if (flush) begin
         req_ready  = '0;
         lane_hit_s = '0;
      end else begin
         for (int k = 0; k < CDB_WIDTH; k++) begin
            req_ready     = req_ready | grant_s[k];
            lane_hit_s[k] = |grant_s[k];
         end
      end
   end

   // Pointer and lane registers; idle lanes keep their stale payload.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_r    <= '0;
         cdb_valid_r <= '0;
         lane_r      <= '0;
      end else begin
         cdb_valid_r <= lane_hit_s;
         for (int k = 0; k < CDB_WIDTH; k++) begin
            if (lane_hit_s[k]) begin
               lane_r[k] <= lane_sel_s[k];
            end
         end
         if (any_grant_s && !flush) begin
            rr_ptr_r <= next_ptr_s;
         end
      end
   end

   // Flatten the lane registers onto the output buses.
   always_comb begin
      cdb_valid    = cdb_valid_r;
      cdb_rd_phy   = '0;
      cdb_rd_value = '0;
      cdb_rob_id   = '0;
      for (int k = 0; k < CDB_WIDTH; k++) begin
         cdb_rd_phy[k*PRF_IDX_W +: PRF_IDX_W] = lane_r[k].rd_phy;
         cdb_rd_value[k*DATA_W +: DATA_W]     = lane_r[k].rd_value;
         cdb_rob_id[k*ROB_IDX_W +: ROB_IDX_W] = lane_r[k].rob_id;
      end
   end

`ifdef CDB_ARB_PERF_EN
   logic [N_REQ-1:0][CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0]            full_cycles_r;

   // Saturating stall and all-lanes-busy counters; flush does not clear them.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_r   <= '0;
         full_cycles_r <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && !req_ready[i]) begin
               stall_cnt_r[i] <= sat_inc(stall_cnt_r[i]);
            end
         end
         if (&lane_hit_s) begin
            full_cycles_r <= sat_inc(full_cycles_r);
         end
      end
   end

   assign stall_cnt   = stall_cnt_r;
   assign full_cycles = full_cycles_r;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: grants, lane payloads, rotation, flush,
// reset priority over flush; perf counters when CDB_ARB_PERF_EN is defined.
module tb_cdb_arbiter;
   import cpu_params::*;

   localparam int N = 4;

   logic                           clk = 1'b0;
   logic                           rst;
   logic                           flush;
   logic [N-1:0]                   req_valid;
   logic [N-1:0]                   req_ready;
   logic [N*PRF_IDX_W-1:0]         req_rd_phy;
   logic [N*DATA_W-1:0]            req_rd_value;
   logic [N*ROB_IDX_W-1:0]         req_rob_id;
   logic [CDB_WIDTH-1:0]           cdb_valid;
   logic [CDB_WIDTH*PRF_IDX_W-1:0] cdb_rd_phy;
   logic [CDB_WIDTH*DATA_W-1:0]    cdb_rd_value;
   logic [CDB_WIDTH*ROB_IDX_W-1:0] cdb_rob_id;
`ifdef CDB_ARB_PERF_EN
   logic [N*CNT_W-1:0]             stall_cnt;
   logic [CNT_W-1:0]               full_cycles;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   cdb_arbiter #(.N_REQ(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_rd_phy   (req_rd_phy),
      .req_rd_value (req_rd_value),
      .req_rob_id   (req_rob_id),
      .cdb_valid    (cdb_valid),
      .cdb_rd_phy   (cdb_rd_phy),
      .cdb_rd_value (cdb_rd_value),
      .cdb_rob_id   (cdb_rob_id)
`ifdef CDB_ARB_PERF_EN
      ,
      .stall_cnt    (stall_cnt),
      .full_cycles  (full_cycles)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Requester i: rd_phy = i+1, value = 0x10000000+i, rob_id = i+10.
   task automatic set_defaults();
      for (int i = 0; i < N; i++) begin
         req_rd_phy[i*PRF_IDX_W +: PRF_IDX_W] = 6'(i + 1);
         req_rd_value[i*DATA_W +: DATA_W]     = 32'h1000_0000 + 32'(i);
         req_rob_id[i*ROB_IDX_W +: ROB_IDX_W] = 5'(i + 10);
      end
   endtask

   function automatic logic [PRF_IDX_W-1:0] lane_phy(input int k);
      return cdb_rd_phy[k*PRF_IDX_W +: PRF_IDX_W];
   endfunction

   function automatic logic [ROB_IDX_W-1:0] lane_rob(input int k);
      return cdb_rob_id[k*ROB_IDX_W +: ROB_IDX_W];
   endfunction

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      req_valid = 4'b0000;
      set_defaults();
      step();
      step();
      check("rst_valid",   64'(cdb_valid),    64'h0);
      check("rst_phy",     64'(cdb_rd_phy),   64'h0);
      check("rst_value",   64'(cdb_rd_value), 64'h0);
      check("rst_rob",     64'(cdb_rob_id),   64'h0);
      check("rst_ready",   64'(req_ready),    64'h0);

      // All valid: grants {0,1}, {2,3}, {0,1}
      rst       = 1'b0;
      req_valid = 4'b1111;
      #1;
      check("all_ready0", 64'(req_ready), 64'h3);
      step();
      check("all_cdbv0",  64'(cdb_valid), 64'h3);
      check("all_l0_0",   64'(lane_phy(0)), 64'd1);
      check("all_l1_0",   64'(lane_phy(1)), 64'd2);
      check("all_ready1", 64'(req_ready), 64'hC);
      step();
      check("all_cdbv1",  64'(cdb_valid), 64'h3);
      check("all_l0_1",   64'(lane_phy(0)), 64'd3);
      check("all_l1_1",   64'(lane_phy(1)), 64'd4);
      check("all_ready2", 64'(req_ready), 64'h3);
      step();
      check("all_l0_2",   64'(lane_phy(0)), 64'd1);
      check("all_l1_2",   64'(lane_phy(1)), 64'd2);

      // Single requester 2 with custom payload (ptr 2 -> 3)
      req_valid = 4'b0100;
      req_rd_phy[2*PRF_IDX_W +: PRF_IDX_W] = 6'd5;
      req_rd_value[2*DATA_W +: DATA_W]     = 32'hDEADBEEF;
      req_rob_id[2*ROB_IDX_W +: ROB_IDX_W] = 5'd7;
      #1;
      check("one_ready",  64'(req_ready), 64'h4);
      step();
      check("one_cdbv",   64'(cdb_valid), 64'h1);
      check("one_phy",    64'(lane_phy(0)), 64'd5);
      check("one_value",  64'(cdb_rd_value[DATA_W-1:0]), 64'hDEADBEEF);
      check("one_rob",    64'(lane_rob(0)), 64'd7);
      set_defaults();

      // ptr 3, valid 1001: lane0 = req3, lane1 = req0 (ptr -> 1)
      req_valid = 4'b1001;
      #1;
      check("wrap_ready", 64'(req_ready), 64'h9);
      step();
      check("wrap_cdbv",  64'(cdb_valid), 64'h3);
      check("wrap_l0",    64'(lane_rob(0)), 64'd13);
      check("wrap_l1",    64'(lane_rob(1)), 64'd10);

      // Flush with all valid: no grants, earlier broadcast still visible
      flush     = 1'b1;
      req_valid = 4'b1111;
      #1;
      check("fl_ready",   64'(req_ready), 64'h0);
      check("fl_cdbv_in", 64'(cdb_valid), 64'h3);
      step();
      check("fl_cdbv",    64'(cdb_valid), 64'h0);
      flush = 1'b0;
      #1;
      check("fl_ptrheld", 64'(req_ready), 64'h6);
      step();
      check("fl_l0",      64'(lane_phy(0)), 64'd2);
      check("fl_l1",      64'(lane_phy(1)), 64'd3);

      // rd_phy = 0 still broadcast (ptr 3 -> 2)
      req_valid = 4'b0010;
      req_rd_phy[1*PRF_IDX_W +: PRF_IDX_W] = 6'd0;
      #1;
      check("p0_ready",   64'(req_ready), 64'h2);
      step();
      check("p0_cdbv",    64'(cdb_valid), 64'h1);
      check("p0_phy",     64'(lane_phy(0)), 64'd0);
      check("p0_rob",     64'(lane_rob(0)), 64'd11);
      set_defaults();

      // Idle cycle: lanes go invalid, ptr stays 2
      req_valid = 4'b0000;
      step();
      check("idle_cdbv",  64'(cdb_valid), 64'h0);

      // Three valid from ptr 2: req2 then req0 (ptr -> 1), then req1, req2
      req_valid = 4'b0111;
      #1;
      check("three_rdy0", 64'(req_ready), 64'h5);
      step();
      check("three_l0",   64'(lane_phy(0)), 64'd3);
      check("three_l1",   64'(lane_phy(1)), 64'd1);
      check("three_rdy1", 64'(req_ready), 64'h6);
      step();
      check("three_l0b",  64'(lane_phy(0)), 64'd2);
      check("three_l1b",  64'(lane_phy(1)), 64'd3);

      // rst and flush together: reset wins, ptr back to 0
      rst       = 1'b1;
      flush     = 1'b1;
      req_valid = 4'b1111;
      step();
      check("rf_cdbv",    64'(cdb_valid), 64'h0);
      check("rf_phy",     64'(cdb_rd_phy), 64'h0);
      rst   = 1'b0;
      flush = 1'b0;
      #1;
      check("rf_ready",   64'(req_ready), 64'h3);

`ifdef CDB_ARB_PERF_EN
      // Ten cycles of full traffic from a fresh reset
      rst = 1'b1;
      step();
      rst = 1'b0;
      req_valid = 4'b1111;
      for (int c = 0; c < 10; c++) begin
         step();
      end
      check("perf_stall3", 64'(stall_cnt[3*CNT_W +: CNT_W]), 64'd5);
      check("perf_stall0", 64'(stall_cnt[0*CNT_W +: CNT_W]), 64'd5);
      check("perf_full",   64'(full_cycles), 64'd10);
`endif

      req_valid = 4'b0000;
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
